// File: rtl/tea_ptxt_packer_pkg.sv
// ---------------------------------------------------------------------------
// tea_pkg
// Shared constants and types for the TEA plaintext packer.
//   TEA_BLK_W          width of one plaintext block in bits
//   TEA_KEY_W          width of the TEA key in bits
//   TEA_BLK_BYTES      number of bytes in one block
//   TEA_PKCS7_FULL_PAD block issued after a message that ends on a block
//                      boundary when PKCS#7 padding is built in
//   tea_pack_state_t   packer FSM states
// ---------------------------------------------------------------------------
package tea_pkg;

  localparam int TEA_BLK_W     = 64;
  localparam int TEA_KEY_W     = 128;
  localparam int TEA_BLK_BYTES = 8;

  localparam logic [TEA_BLK_W-1:0] TEA_PKCS7_FULL_PAD = {TEA_BLK_BYTES{8'h08}};

  typedef enum logic [2:0] {
    FILL,
    PAD,
    WAIT,
    GAP,
    PADBLK
  } tea_pack_state_t;

endpackage

// File: rtl/tea_ptxt_packer_if.sv
// ---------------------------------------------------------------------------
// tea_ptxt_packer_if
// Bundles the byte-stream input and the block/key output of the packer.
//   din, din_valid, din_last, din_ready   byte stream from the feeder
//   ptxt_blk, ptxt_valid, key, key_valid  block and key towards the TEA core
//   ctxt_ready                            TEA core finished the current block
//   blk_last                              block is the final one of a message
// Modports:
//   master  the packer itself (accepts bytes, drives blocks)
//   slave   the environment around it (feeder plus TEA core)
// ---------------------------------------------------------------------------
interface tea_ptxt_packer_if;
  import tea_pkg::*;

  logic [7:0]           din;
  logic                 din_valid;
  logic                 din_last;
  logic                 din_ready;
  logic [TEA_BLK_W-1:0] ptxt_blk;
  logic                 ptxt_valid;
  logic [TEA_KEY_W-1:0] key;
  logic                 key_valid;
  logic                 ctxt_ready;
  logic                 blk_last;

  modport master (
    input  din, din_valid, din_last, ctxt_ready,
    output din_ready, ptxt_blk, ptxt_valid, key, key_valid, blk_last
  );

  modport slave (
    output din, din_valid, din_last, ctxt_ready,
    input  din_ready, ptxt_blk, ptxt_valid, key, key_valid, blk_last
  );

endinterface

// File: rtl/tea_ptxt_packer_pad_gen.sv
// ---------------------------------------------------------------------------
// tea_pad_gen
// Combinational padder: keeps the first byte_cnt lanes of blk_in (lane 0 is
// bits [63:56]) and overwrites every later lane with the pad value.
//   blk_in    partially filled block
//   byte_cnt  number of valid bytes already in blk_in (1..7)
//   blk_out   padded block
// Build option TEA_PKCS7_PAD_EN: pad value is the pad-byte count (PKCS#7)
// instead of PAD_BYTE.
// ---------------------------------------------------------------------------
module tea_pad_gen
  import tea_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic [TEA_BLK_W-1:0] blk_in,
  input  logic [2:0]           byte_cnt,
  output logic [TEA_BLK_W-1:0] blk_out
);

  logic [7:0] pad_val;

  // Pick the pad value, then overwrite every lane at or beyond byte_cnt.
  always_comb begin
`ifdef TEA_PKCS7_PAD_EN
    pad_val = 8'(4'd8 - {1'b0, byte_cnt});
`else
    pad_val = PAD_BYTE;
`endif
    blk_out = blk_in;
    for (int i = 0; i < TEA_BLK_BYTES; i++) begin
      if (i >= int'(byte_cnt)) begin
        blk_out[TEA_BLK_W-1-8*i -: 8] = pad_val;
      end
    end
  end

endmodule

// File: rtl/tea_ptxt_packer.sv
// ---------------------------------------------------------------------------
// tea_ptxt_packer
// Packs a byte stream into 64-bit TEA plaintext blocks (first byte in bits
// [63:56]), pads the final partial block and holds each block and the key
// steady towards the TEA core until the core signals ctxt_ready.
// Ports:
//   clk, rst   single clock, synchronous active-high reset
//   key_in     key source, captured on key_load while idle
//   key_load   capture request, honoured only in FILL with no bytes buffered
//   bus        tea_ptxt_packer_if.master: byte stream in, block/key out
//   busy       high unless idle (FILL with no bytes buffered)
//   blk_cnt    blocks completed by the core, wraps at 2^CNT_W
// Build option TEA_PKCS7_PAD_EN: PKCS#7 padding, including an extra all-08
// block after a message that ends exactly on a block boundary.
// ---------------------------------------------------------------------------
module tea_ptxt_packer
  import tea_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TEA_KEY_W-1:0] key_in,
  input  logic                 key_load,
  tea_ptxt_packer_if.master    bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     blk_cnt
);

  tea_pack_state_t      state_q, state_d;
  logic [2:0]           byte_idx_q, byte_idx_d;
  logic [TEA_BLK_W-1:0] blk_q, blk_d;
  logic [TEA_KEY_W-1:0] key_q, key_d;
  logic                 blk_last_q, blk_last_d;
  logic [CNT_W-1:0]     blk_cnt_q, blk_cnt_d;
`ifdef TEA_PKCS7_PAD_EN
  logic                 pad_pend_q, pad_pend_d;
`endif

  logic                 idle;
  logic                 din_fire;
  logic [TEA_BLK_W-1:0] padded_blk;

  // In PAD, byte_idx_q holds the number of bytes received for this block.
  tea_pad_gen #(
    .PAD_BYTE (PAD_BYTE)
  ) u_pad_gen (
    .blk_in   (blk_q),
    .byte_cnt (byte_idx_q),
    .blk_out  (padded_blk)
  );

  // Handshake and status decode straight from the registered state.
  always_comb begin
    idle          = (state_q == FILL) && (byte_idx_q == 3'd0);
    bus.din_ready = (state_q == FILL);
    din_fire      = bus.din_valid && bus.din_ready;
    busy          = !idle;
  end

  // Block outputs come directly from flops, so they cannot glitch while
  // the core is working on them.
  always_comb begin
    bus.ptxt_blk   = blk_q;
    bus.ptxt_valid = (state_q == WAIT);
    bus.key_valid  = (state_q == WAIT);
    bus.key        = key_q;
    bus.blk_last   = blk_last_q;
    blk_cnt        = blk_cnt_q;
  end

  // Next-state logic. A message that ends on a block boundary under PKCS#7
  // defers its blk_last to the extra PADBLK block via pad_pend.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    blk_d      = blk_q;
    key_d      = key_q;
    blk_last_d = blk_last_q;
    blk_cnt_d  = blk_cnt_q;
`ifdef TEA_PKCS7_PAD_EN
    pad_pend_d = pad_pend_q;
`endif
    case (state_q)
      FILL: begin
        if (key_load && idle) begin
          key_d = key_in;
        end
        if (din_fire) begin
          for (int i = 0; i < TEA_BLK_BYTES; i++) begin
            if (3'(i) == byte_idx_q) begin
              blk_d[TEA_BLK_W-1-8*i -: 8] = bus.din;
            end
          end
          if (byte_idx_q == 3'd7) begin
            byte_idx_d = 3'd0;
            state_d    = WAIT;
`ifdef TEA_PKCS7_PAD_EN
            blk_last_d = 1'b0;
            pad_pend_d = bus.din_last;
`else
            blk_last_d = bus.din_last;
`endif
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            if (bus.din_last) begin
              blk_last_d = 1'b1;
              state_d    = PAD;
            end
          end
        end
      end
      PAD: begin
        blk_d      = padded_blk;
        byte_idx_d = 3'd0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (bus.ctxt_ready) begin
          blk_cnt_d = blk_cnt_q + CNT_W'(1);
          state_d   = GAP;
        end
      end
      GAP: begin
        blk_last_d = 1'b0;
`ifdef TEA_PKCS7_PAD_EN
        state_d    = pad_pend_q ? PADBLK : FILL;
`else
        state_d    = FILL;
`endif
      end
`ifdef TEA_PKCS7_PAD_EN
      PADBLK: begin
        blk_d      = TEA_PKCS7_FULL_PAD;
        blk_last_d = 1'b1;
        pad_pend_d = 1'b0;
        state_d    = WAIT;
      end
`endif
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State register; reset discards any partially packed block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      byte_idx_q <= 3'd0;
      blk_q      <= '0;
      key_q      <= '0;
      blk_last_q <= 1'b0;
      blk_cnt_q  <= '0;
`ifdef TEA_PKCS7_PAD_EN
      pad_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      blk_q      <= blk_d;
      key_q      <= key_d;
      blk_last_q <= blk_last_d;
      blk_cnt_q  <= blk_cnt_d;
`ifdef TEA_PKCS7_PAD_EN
      pad_pend_q <= pad_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_tea_ptxt_packer.sv
// ---------------------------------------------------------------------------
// tb_tea_ptxt_packer
// Scoreboard bench for tea_ptxt_packer. Messages are turned into expected
// blocks by a byte-level reference model and queued; a TEA core model
// answers each block 32 cycles after valid and checks the block, key,
// blk_last, stability while waiting and the block counter.
// Honours TEA_PKCS7_PAD_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_tea_ptxt_packer;
  import tea_pkg::*;

  localparam logic [7:0] PAD_BYTE = 8'h00;
  localparam int         CNT_W    = 16;
  localparam int         CORE_LAT = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [TEA_KEY_W-1:0] key_in;
  logic                 key_load;
  logic                 busy;
  logic [CNT_W-1:0]     blk_cnt;

  tea_ptxt_packer_if bus ();

  tea_ptxt_packer #(
    .PAD_BYTE (PAD_BYTE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_load (key_load),
    .bus      (bus.master),
    .busy     (busy),
    .blk_cnt  (blk_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TEA_BLK_W-1:0] blk;
    logic                 last;
    logic [TEA_KEY_W-1:0] key;
  } exp_blk_t;

  exp_blk_t             expQ[$];
  logic [TEA_KEY_W-1:0] expKey = '0;
  logic [CNT_W-1:0]     expCnt = '0;
  int                   compared = 0;
  int                   mismatched = 0;

  // Core model / monitor state
  logic                 prevValid = 1'b0;
  logic                 coreDrove = 1'b0;
  logic [TEA_BLK_W-1:0] heldBlk = '0;
  logic                 heldLast = 1'b0;
  int                   waitCyc = 0;

  // One comparison: counted always, reported only on a difference.
  task automatic checkOutput(input string name, input logic [TEA_KEY_W-1:0] act,
                             input logic [TEA_KEY_W-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model: chop the message into 8-byte blocks, pad the tail and,
  // for PKCS#7, append a full pad block when the length is a multiple of 8.
  task automatic pushMessage(input logic [7:0] msg[$]);
    int       n;
    int       nblk;
    int       padCnt;
    logic [7:0] b;
    exp_blk_t e;
    n      = msg.size();
    nblk   = (n + 7) / 8;
    padCnt = nblk * 8 - n;
    for (int k = 0; k < nblk; k++) begin
      e.blk = '0;
      for (int j = 0; j < 8; j++) begin
        if (k * 8 + j < n) b = msg[k*8+j];
`ifdef TEA_PKCS7_PAD_EN
        else b = 8'(padCnt);
`else
        else b = PAD_BYTE;
`endif
        e.blk = {e.blk[55:0], b};
      end
`ifdef TEA_PKCS7_PAD_EN
      e.last = (k == nblk - 1) && (padCnt != 0);
`else
      e.last = (k == nblk - 1);
`endif
      e.key = expKey;
      expQ.push_back(e);
    end
`ifdef TEA_PKCS7_PAD_EN
    if (padCnt == 0) begin
      e.blk  = {8{8'h08}};
      e.last = 1'b1;
      e.key  = expKey;
      expQ.push_back(e);
    end
`endif
  endtask

  // Present one byte from a negedge and hold it until a transfer edge.
  // Returns at the negedge right after the transfer.
  task automatic driveByte(input logic [7:0] b, input logic last);
    logic rdy;
    int   budget;
    bus.din       = b;
    bus.din_valid = 1'b1;
    bus.din_last  = last;
    budget        = 0;
    forever begin
      rdy = bus.din_ready;
      @(negedge clk);
      if (rdy) break;
      budget++;
      if (budget > 500) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL din_accept_timeout: byte %h not accepted", b);
        break;
      end
    end
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
  endtask

  // Send a whole message, optionally with random bubbles and a latency check
  // on the final byte.
  task automatic applyStimulus(input logic [7:0] msg[$], input bit gaps, input bit chkLat);
    int n;
    n = msg.size();
    pushMessage(msg);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
      driveByte(msg[i], (i == n - 1));
    end
    if (chkLat) begin
      checkOutput("valid_latency_1", 128'(bus.ptxt_valid), 128'((n % 8) == 0));
      if ((n % 8) != 0) begin
        @(negedge clk);
        checkOutput("valid_latency_2", 128'(bus.ptxt_valid), 128'd1);
      end
    end
  endtask

  // Wait until every queued block has been consumed and the packer is idle.
  task automatic waitIdle();
    int budget;
    budget = 0;
    while (expQ.size() != 0 || busy || bus.ptxt_valid) begin
      @(negedge clk);
      budget++;
      if (budget > 3000) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL drain_timeout: %0d blocks still expected", expQ.size());
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic loadKey(input logic [TEA_KEY_W-1:0] k, input bit expectTaken);
    key_in   = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    if (expectTaken) expKey = k;
    checkOutput("key_reg", bus.key, expKey);
  endtask

  // TEA core model and scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (coreDrove) begin
      bus.ctxt_ready = 1'b0;
      coreDrove      = 1'b0;
      checkOutput("gap_valid_low", 128'(bus.ptxt_valid), 128'd0);
      checkOutput("blk_cnt", 128'(blk_cnt), 128'(expCnt));
    end else if (bus.ptxt_valid && !rst) begin
      if (!prevValid) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_block: got %h with nothing expected", bus.ptxt_blk);
        end else begin
          exp_blk_t e;
          e = expQ.pop_front();
          checkOutput("ptxt_blk", 128'(bus.ptxt_blk), 128'(e.blk));
          checkOutput("blk_last", 128'(bus.blk_last), 128'(e.last));
          checkOutput("key", bus.key, e.key);
          checkOutput("key_valid", 128'(bus.key_valid), 128'd1);
        end
        heldBlk  = bus.ptxt_blk;
        heldLast = bus.blk_last;
        waitCyc  = 0;
      end else begin
        checkOutput("hold_stable", {63'd0, bus.ptxt_blk, bus.blk_last},
                    {63'd0, heldBlk, heldLast});
        checkOutput("din_ready_in_wait", 128'(bus.din_ready), 128'd0);
      end
      waitCyc++;
      if (waitCyc == CORE_LAT) begin
        bus.ctxt_ready = 1'b1;
        coreDrove      = 1'b1;
        expCnt         = expCnt + 1'b1;
      end
    end
    prevValid = bus.ptxt_valid;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] msg[$];
    rst            = 1'b1;
    key_in         = '0;
    key_load       = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.din_last   = 1'b0;
    bus.ctxt_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_ptxt_valid", 128'(bus.ptxt_valid), 128'd0);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_blk_cnt", 128'(blk_cnt), 128'd0);
    checkOutput("reset_key", bus.key, 128'd0);

    $display("[TB] directed: single full block with key");
    loadKey(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
    msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    applyStimulus(msg, 1'b0, 1'b1);
    waitIdle();

    $display("[TB] directed: three byte message with pad");
    msg = '{8'hAA, 8'hBB, 8'hCC};
    applyStimulus(msg, 1'b0, 1'b1);
    waitIdle();

    $display("[TB] directed: back-to-back messages, din held during wait");
    msg = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29};
    applyStimulus(msg, 1'b0, 1'b0);
    msg = '{8'h31, 8'h32};
    applyStimulus(msg, 1'b0, 1'b0);
    waitIdle();

    $display("[TB] directed: ctxt_ready while idle");
    bus.ctxt_ready = 1'b1;
    @(negedge clk);
    bus.ctxt_ready = 1'b0;
    @(negedge clk);
    checkOutput("blk_cnt_idle_ready", 128'(blk_cnt), 128'(expCnt));

    $display("[TB] directed: key_load during wait then idle");
    msg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
    applyStimulus(msg, 1'b0, 1'b0);
    loadKey(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b0);
    waitIdle();
    loadKey(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b1);

    $display("[TB] directed: reset mid-block");
    driveByte(8'h51, 1'b0);
    driveByte(8'h52, 1'b0);
    driveByte(8'h53, 1'b0);
    driveByte(8'h54, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    expKey = '0;
    expCnt = '0;
    checkOutput("rst_ptxt_blk", 128'(bus.ptxt_blk), 128'd0);
    checkOutput("rst_valid", {126'd0, bus.ptxt_valid, bus.key_valid}, 128'd0);
    checkOutput("rst_key", bus.key, 128'd0);
    checkOutput("rst_misc", {125'd0, bus.blk_last, busy, 1'b0}, 128'd0);
    checkOutput("rst_blk_cnt", 128'(blk_cnt), 128'd0);
    msg = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    applyStimulus(msg, 1'b0, 1'b1);
    waitIdle();

    $display("[TB] random messages");
    for (int m = 0; m < 25; m++) begin
      int len;
      if ($urandom_range(0, 4) == 0) begin
        waitIdle();
        loadKey({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      end
      len = $urandom_range(1, 20);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      applyStimulus(msg, 1'b1, 1'b0);
    end
    waitIdle();
    checkOutput("final_blk_cnt", 128'(blk_cnt), 128'(expCnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
